// File: rtl/uart_pkg.sv
// Frame constants and receive FSM encoding shared by the UART receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; 2 clk latency, resets to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled mid-bit sampling, one-clk data_valid or frame_err strobe
// registered after the stop-bit tick; no backpressure, the consumer must take each byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_in),
    .q   (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      armed      <= 1'b1;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_en) begin
        case (state)
          IDLE: begin
            // After a framing error the line must go high again before a new start counts.
            if (rxs) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == HALF_TICK) begin
              if (rxs) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == LAST_TICK) begin
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          STOP: begin
            tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == LAST_TICK) begin
              if (rxs) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
